// File: rtl/bsg_manycore_host_endpoint.sv
// Host-side endpoint on manycore io port (0,0): injects host requests under credit flow
// control, buffers rev responses and tile->host requests, and answers consumed requests.

module bsg_manycore_host_endpoint_fifo #(
    parameter int unsigned width_p = 1,
    parameter int unsigned els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] els_cnt_lp  = cnt_width_lp'(els_p);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] rd_ptr_r;
    logic [ptr_width_lp-1:0] wr_ptr_r;
    logic [cnt_width_lp-1:0] count_r;

    assign full_o  = (count_r == els_cnt_lp);
    assign empty_o = (count_r == '0);
    assign data_o  = mem_r[rd_ptr_r];

    always_ff @(posedge clk_i) begin
        if (enq_i) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq_i) begin
                wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + ptr_width_lp'(1);
            end
            if (deq_i) begin
                rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + ptr_width_lp'(1);
            end
            if (enq_i && !deq_i) begin
                count_r <= count_r + cnt_width_lp'(1);
            end else if (!enq_i && deq_i) begin
                count_r <= count_r - cnt_width_lp'(1);
            end
        end
    end
endmodule

module bsg_manycore_host_endpoint #(
    parameter int addr_width_p      = 28,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 3,
    parameter int load_id_width_p   = 5,
    parameter int max_out_credits_p = 16,
    parameter int rsp_fifo_els_p    = 4,
    parameter int in_fifo_els_p     = 2,
    localparam int packet_width_lp = addr_width_p + 2 + load_id_width_p + data_width_p
                                   + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int return_packet_width_lp = 2 + data_width_p + load_id_width_p
                                          + x_cord_width_p + y_cord_width_p,
    localparam int link_sif_width_lp = 4 + packet_width_lp + return_packet_width_lp,
    localparam int credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [link_sif_width_lp-1:0] link_sif_i,
    output logic [link_sif_width_lp-1:0] link_sif_o,
    input  logic                         host_req_v_i,
    input  logic [packet_width_lp-1:0]   host_req_i,
    output logic                         host_req_ready_o,
    output logic                         host_rsp_v_o,
    output logic [data_width_p-1:0]      host_rsp_data_o,
    output logic [load_id_width_p-1:0]   host_rsp_load_id_o,
    output logic [1:0]                   host_rsp_type_o,
    input  logic                         host_rsp_yumi_i,
    output logic                         host_in_v_o,
    output logic [packet_width_lp-1:0]   host_in_packet_o,
    input  logic                         host_in_yumi_i,
    output logic [credit_width_lp-1:0]   out_credits_o
);
    typedef enum logic [1:0] {
        e_remote_load  = 2'd0,
        e_remote_store = 2'd1,
        e_remote_amo   = 2'd2,
        e_remote_nop   = 2'd3
    } packet_op_e;

    typedef enum logic [1:0] {
        e_return_credit = 2'd0,
        e_return_int    = 2'd1,
        e_return_float  = 2'd2,
        e_return_ifetch = 2'd3
    } return_packet_type_e;

    typedef struct packed {
        logic [addr_width_p-1:0]    addr;
        logic [1:0]                 op;
        logic [load_id_width_p-1:0] reg_id;
        logic [data_width_p-1:0]    payload;
        logic [y_cord_width_p-1:0]  src_y_cord;
        logic [x_cord_width_p-1:0]  src_x_cord;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } packet_s;

    typedef struct packed {
        logic [1:0]                 pkt_type;
        logic [data_width_p-1:0]    data;
        logic [load_id_width_p-1:0] load_id;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } return_packet_s;

    typedef struct packed {
        logic    v;
        packet_s data;
        logic    ready_and_rev;
    } fwd_link_s;

    typedef struct packed {
        logic           v;
        return_packet_s data;
        logic           ready_and_rev;
    } rev_link_s;

    typedef struct packed {
        rev_link_s rev;
        fwd_link_s fwd;
    } link_sif_s;

    typedef struct packed {
        logic [1:0]                 pkt_type;
        logic [data_width_p-1:0]    data;
        logic [load_id_width_p-1:0] load_id;
    } rsp_entry_s;

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    link_sif_s                  link_in;
    link_sif_s                  link_out;
    logic [credit_width_lp-1:0] credits_r;
    logic                       has_credit;
    logic                       fwd_v;
    logic                       send;
    logic                       rsp_full;
    logic                       rsp_empty;
    logic                       rev_ready;
    logic                       rsp_enq;
    logic                       rsp_deq;
    rsp_entry_s                 rsp_entry_in;
    rsp_entry_s                 rsp_head;
    logic                       in_full;
    logic                       in_empty;
    logic                       fwd_ready;
    logic                       in_enq;
    logic                       in_deq;
    packet_s                    in_head;
    logic                       unused_rev_cord;

    assign link_in    = link_sif_i;
    assign link_sif_o = link_out;

    // Outbound requests are combinational pass-through, gated only by credits.
    assign has_credit       = (credits_r != '0);
    assign fwd_v            = ~reset_i & host_req_v_i & has_credit;
    assign send             = fwd_v & link_in.fwd.ready_and_rev;
    assign host_req_ready_o = ~reset_i & link_in.fwd.ready_and_rev & has_credit;

    assign rev_ready    = ~reset_i & ~rsp_full;
    assign rsp_enq      = link_in.rev.v & rev_ready;
    assign rsp_deq      = host_rsp_yumi_i & host_rsp_v_o;
    assign rsp_entry_in = '{pkt_type: link_in.rev.data.pkt_type,
                            data:     link_in.rev.data.data,
                            load_id:  link_in.rev.data.load_id};

    assign unused_rev_cord = ^{link_in.rev.data.y_cord, link_in.rev.data.x_cord};

    bsg_manycore_host_endpoint_fifo #(
        .width_p ($bits(rsp_entry_s)),
        .els_p   (rsp_fifo_els_p)
    ) rsp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enq_i   (rsp_enq),
        .data_i  (rsp_entry_in),
        .deq_i   (rsp_deq),
        .data_o  (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

    assign host_rsp_v_o       = ~reset_i & ~rsp_empty;
    assign host_rsp_data_o    = rsp_head.data;
    assign host_rsp_load_id_o = rsp_head.load_id;
    assign host_rsp_type_o    = rsp_head.pkt_type;

    assign fwd_ready = ~reset_i & ~in_full;
    assign in_enq    = link_in.fwd.v & fwd_ready;

    bsg_manycore_host_endpoint_fifo #(
        .width_p (packet_width_lp),
        .els_p   (in_fifo_els_p)
    ) in_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enq_i   (in_enq),
        .data_i  (link_in.fwd.data),
        .deq_i   (in_deq),
        .data_o  (in_head),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    // Inbound requests are only offered while rev can accept, so the reply never stalls.
    assign host_in_v_o      = ~reset_i & ~in_empty & link_in.rev.ready_and_rev;
    assign host_in_packet_o = in_head;
    assign in_deq           = host_in_yumi_i & host_in_v_o;

    always_comb begin
        link_out                   = '0;
        link_out.fwd.v             = fwd_v;
        link_out.fwd.data          = host_req_i;
        link_out.fwd.ready_and_rev = fwd_ready;
        link_out.rev.v             = in_deq;
        link_out.rev.data.pkt_type = (in_head.op == e_remote_load) ? e_return_int : e_return_credit;
        link_out.rev.data.data     = '0;
        link_out.rev.data.load_id  = in_head.reg_id;
        link_out.rev.data.y_cord   = in_head.src_y_cord;
        link_out.rev.data.x_cord   = in_head.src_x_cord;
        link_out.rev.ready_and_rev = rev_ready;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_r <= max_credits_lp;
        end else if (send && !rsp_enq) begin
            credits_r <= credits_r - credit_width_lp'(1);
        end else if (!send && rsp_enq && (credits_r != max_credits_lp)) begin
            credits_r <= credits_r + credit_width_lp'(1);
        end
    end

    assign out_credits_o = credits_r;

    credit_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(rsp_enq && !send && (credits_r == max_credits_lp)))
        else $error("host endpoint: response received with all credits already returned");

    yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        host_in_yumi_i |-> host_in_v_o)
        else $error("host endpoint: host_in_yumi_i asserted while host_in_v_o is low");
endmodule

// File: tb/tb_bsg_manycore_host_endpoint.sv
// Scoreboard bench for bsg_manycore_host_endpoint: directed stimulus pushes expected
// packets/responses into queues, negedge monitors pop and compare on each DUT handshake.

module tb_bsg_manycore_host_endpoint;
    localparam int aw = 8;
    localparam int dw = 32;
    localparam int xw = 4;
    localparam int yw = 3;
    localparam int lw = 5;
    localparam int pkt_w  = aw + 2 + lw + dw + 2 * (xw + yw);
    localparam int ret_w  = 2 + dw + lw + xw + yw;
    localparam int link_w = 4 + pkt_w + ret_w;
    localparam int cred_w = 5;

    typedef struct packed {
        logic [aw-1:0] addr;
        logic [1:0]    op;
        logic [lw-1:0] reg_id;
        logic [dw-1:0] payload;
        logic [yw-1:0] src_y_cord;
        logic [xw-1:0] src_x_cord;
        logic [yw-1:0] y_cord;
        logic [xw-1:0] x_cord;
    } packet_s;

    typedef struct packed {
        logic [1:0]    pkt_type;
        logic [dw-1:0] data;
        logic [lw-1:0] load_id;
        logic [yw-1:0] y_cord;
        logic [xw-1:0] x_cord;
    } return_packet_s;

    typedef struct packed { logic v; packet_s data; logic ready_and_rev; } fwd_link_s;
    typedef struct packed { logic v; return_packet_s data; logic ready_and_rev; } rev_link_s;
    typedef struct packed { rev_link_s rev; fwd_link_s fwd; } link_sif_s;

    localparam logic [1:0] op_load  = 2'd0;
    localparam logic [1:0] op_store = 2'd1;
    localparam logic [1:0] rt_credit = 2'd0;
    localparam logic [1:0] rt_int    = 2'd1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    link_sif_s         li;
    link_sif_s         lo;
    logic              host_req_v;
    packet_s           host_req;
    logic              host_req_ready;
    logic              rsp_v;
    logic [dw-1:0]     rsp_data;
    logic [lw-1:0]     rsp_load_id;
    logic [1:0]        rsp_type;
    logic              rsp_yumi;
    logic              in_v;
    packet_s           in_packet;
    logic              in_yumi;
    logic [cred_w-1:0] credits;

    int checks   = 0;
    int failures = 0;

    packet_s                     q_fwd[$];
    logic [2+dw+lw-1:0]          q_rsp[$];
    return_packet_s              q_rev[$];

    always #5 clk = ~clk;

    bsg_manycore_host_endpoint #(
        .addr_width_p      (aw),
        .data_width_p      (dw),
        .x_cord_width_p    (xw),
        .y_cord_width_p    (yw),
        .load_id_width_p   (lw),
        .max_out_credits_p (16),
        .rsp_fifo_els_p    (4),
        .in_fifo_els_p     (2)
    ) dut (
        .clk_i              (clk),
        .reset_i            (rst),
        .link_sif_i         (li),
        .link_sif_o         (lo),
        .host_req_v_i       (host_req_v),
        .host_req_i         (host_req),
        .host_req_ready_o   (host_req_ready),
        .host_rsp_v_o       (rsp_v),
        .host_rsp_data_o    (rsp_data),
        .host_rsp_load_id_o (rsp_load_id),
        .host_rsp_type_o    (rsp_type),
        .host_rsp_yumi_i    (rsp_yumi),
        .host_in_v_o        (in_v),
        .host_in_packet_o   (in_packet),
        .host_in_yumi_i     (in_yumi),
        .out_credits_o      (credits)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic packet_s mk_pkt(input logic [1:0] op, input logic [lw-1:0] id,
                                       input logic [dw-1:0] d, input logic [xw-1:0] sx,
                                       input logic [yw-1:0] sy, input logic [aw-1:0] addr);
        packet_s p;
        p.addr = addr; p.op = op; p.reg_id = id; p.payload = d;
        p.src_y_cord = sy; p.src_x_cord = sx; p.y_cord = 3'd2; p.x_cord = 4'd1;
        return p;
    endfunction

    function automatic return_packet_s mk_ret(input logic [1:0] t, input logic [dw-1:0] d,
                                              input logic [lw-1:0] id, input logic [yw-1:0] y,
                                              input logic [xw-1:0] x);
        return_packet_s r;
        r.pkt_type = t; r.data = d; r.load_id = id; r.y_cord = y; r.x_cord = x;
        return r;
    endfunction

    // Offer one rev response on the network and record what the host should later pop.
    task automatic offer_rsp(input logic [dw-1:0] d, input logic [lw-1:0] id);
        li.rev.v    = 1'b1;
        li.rev.data = mk_ret(rt_int, d, id, 3'd0, 4'd0);
        q_rsp.push_back({rt_int, d, id});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        packet_s e;
        if (lo.fwd.v && li.fwd.ready_and_rev) begin
            if (q_fwd.size() == 0) begin
                checks++; failures++;
                $display("FAIL fwd_send: unexpected packet %0h, none expected", lo.fwd.data);
            end else begin
                e = q_fwd.pop_front();
                check("fwd_send", 64'(lo.fwd.data), 64'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [2+dw+lw-1:0] e;
        if (rsp_v && rsp_yumi) begin
            if (q_rsp.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp_pop: unexpected response %0h, none expected", {rsp_type, rsp_data, rsp_load_id});
            end else begin
                e = q_rsp.pop_front();
                check("rsp_pop", 64'({rsp_type, rsp_data, rsp_load_id}), 64'(e));
            end
        end
    end

    always @(negedge clk) begin
        return_packet_s e;
        if (lo.rev.v) begin
            if (q_rev.size() == 0) begin
                checks++; failures++;
                $display("FAIL rev_out: unexpected return packet %0h, none expected", lo.rev.data);
            end else begin
                e = q_rev.pop_front();
                check("rev_out", 64'(lo.rev.data), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        packet_s p;
        li         = '0;
        host_req_v = 1'b0;
        host_req   = '0;
        rsp_yumi   = 1'b0;
        in_yumi    = 1'b0;
        cyc();
        cyc();

        // Reset: outputs held quiet even with traffic offered.
        host_req_v = 1'b1;
        li.fwd.ready_and_rev = 1'b1;
        li.rev.ready_and_rev = 1'b1;
        #1;
        check("rst_fwd_v", 64'(lo.fwd.v), 64'd0);
        check("rst_rev_v", 64'(lo.rev.v), 64'd0);
        check("rst_fwd_ready", 64'(lo.fwd.ready_and_rev), 64'd0);
        check("rst_rev_ready", 64'(lo.rev.ready_and_rev), 64'd0);
        check("rst_rsp_v", 64'(rsp_v), 64'd0);
        check("rst_in_v", 64'(in_v), 64'd0);
        host_req_v = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_credits", 64'(credits), 64'd16);

        // 16 back-to-back sends drain the credits.
        for (int i = 0; i < 16; i++) begin
            p = mk_pkt(op_store, lw'(i), 32'h1111_1111 * i, 4'd0, 3'd0, aw'(i));
            host_req_v = 1'b1;
            host_req   = p;
            q_fwd.push_back(p);
            #1;
            check("burst_credits", 64'(credits), 64'(16 - i));
            check("burst_ready", 64'(host_req_ready), 64'd1);
            cyc();
        end
        host_req = mk_pkt(op_store, 5'd31, 32'hBAD0_BAD0, 4'd0, 3'd0, 8'hFF);
        #1;
        check("zero_credits", 64'(credits), 64'd0);
        check("zero_ready", 64'(host_req_ready), 64'd0);
        check("zero_fwd_v", 64'(lo.fwd.v), 64'd0);
        cyc();
        host_req_v = 1'b0;

        // One response from zero credits.
        offer_rsp(32'hDEAD_BEEF, 5'd3);
        #1;
        check("rsp_ready", 64'(lo.rev.ready_and_rev), 64'd1);
        cyc();
        li.rev.v = 1'b0;
        #1;
        check("rsp_credit", 64'(credits), 64'd1);
        check("rsp_v", 64'(rsp_v), 64'd1);
        check("rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
        check("rsp_load_id", 64'(rsp_load_id), 64'd3);
        rsp_yumi = 1'b1;
        cyc();
        rsp_yumi = 1'b0;

        // Fill the response FIFO: r0..r3.
        for (int k = 0; k < 4; k++) begin
            offer_rsp(32'h1000 + dw'(k), lw'(4 + k));
            cyc();
        end
        li.rev.v = 1'b0;
        #1;
        check("fill_credits", 64'(credits), 64'd5);
        check("fill_ready", 64'(lo.rev.ready_and_rev), 64'd0);
        rsp_yumi = 1'b1;
        cyc();
        rsp_yumi = 1'b0;

        // Send and response enqueue in the same cycle at credits=5.
        p = mk_pkt(op_load, 5'd12, 32'h0, 4'd0, 3'd0, 8'h33);
        host_req_v = 1'b1;
        host_req   = p;
        q_fwd.push_back(p);
        offer_rsp(32'h1004, 5'd8);
        #1;
        check("both_pre_credits", 64'(credits), 64'd5);
        check("both_rev_ready", 64'(lo.rev.ready_and_rev), 64'd1);
        cyc();
        host_req_v = 1'b0;
        li.rev.v   = 1'b0;
        #1;
        check("both_credits", 64'(credits), 64'd5);

        // Full FIFO holds off the next response until the host pops one.
        offer_rsp(32'h1005, 5'd9);
        #1;
        check("full_ready", 64'(lo.rev.ready_and_rev), 64'd0);
        cyc();
        check("held_credits", 64'(credits), 64'd5);
        rsp_yumi = 1'b1;
        cyc();
        rsp_yumi = 1'b0;
        #1;
        check("ready_returns", 64'(lo.rev.ready_and_rev), 64'd1);
        check("not_yet_credits", 64'(credits), 64'd5);
        cyc();
        li.rev.v = 1'b0;
        #1;
        check("held_enq_credits", 64'(credits), 64'd6);
        rsp_yumi = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        rsp_yumi = 1'b0;
        #1;
        check("drained_rsp_v", 64'(rsp_v), 64'd0);

        // Tile store to host from (2,1).
        p = mk_pkt(op_store, 5'd9, 32'hCAFE_0001, 4'd2, 3'd1, 8'h40);
        li.fwd.v    = 1'b1;
        li.fwd.data = p;
        #1;
        check("in_fwd_ready", 64'(lo.fwd.ready_and_rev), 64'd1);
        cyc();
        li.fwd.v = 1'b0;
        #1;
        check("in_v", 64'(in_v), 64'd1);
        check("in_packet", 64'(in_packet), 64'(p));
        li.rev.ready_and_rev = 1'b0;
        #1;
        check("in_v_blocked", 64'(in_v), 64'd0);
        li.rev.ready_and_rev = 1'b1;
        in_yumi = 1'b1;
        q_rev.push_back(mk_ret(rt_credit, 32'h0, 5'd9, 3'd1, 4'd2));
        #1;
        check("yumi_rev_v", 64'(lo.rev.v), 64'd1);
        cyc();
        in_yumi = 1'b0;
        #1;
        check("in_v_after", 64'(in_v), 64'd0);

        // Fill the inbound FIFO with a load then a store.
        p = mk_pkt(op_load, 5'd17, 32'h0, 4'd3, 3'd2, 8'h10);
        li.fwd.v    = 1'b1;
        li.fwd.data = p;
        cyc();
        li.fwd.data = mk_pkt(op_store, 5'd4, 32'h55AA_55AA, 4'd1, 3'd0, 8'h11);
        cyc();
        li.fwd.v = 1'b0;
        #1;
        check("in_full_ready", 64'(lo.fwd.ready_and_rev), 64'd0);
        check("in_head", 64'(in_packet), 64'(p));
        in_yumi = 1'b1;
        q_rev.push_back(mk_ret(rt_int, 32'h0, 5'd17, 3'd2, 4'd3));
        cyc();
        q_rev.push_back(mk_ret(rt_credit, 32'h0, 5'd4, 3'd0, 4'd1));
        cyc();
        in_yumi = 1'b0;
        #1;
        check("in_drained_v", 64'(in_v), 64'd0);
        check("in_drained_ready", 64'(lo.fwd.ready_and_rev), 64'd1);

        // Reach 7 outstanding with 2 queued responses and a queued inbound request.
        offer_rsp(32'h2000, 5'd1);
        li.fwd.v    = 1'b1;
        li.fwd.data = mk_pkt(op_store, 5'd2, 32'h7777_0000, 4'd5, 3'd4, 8'h22);
        cyc();
        li.fwd.v = 1'b0;
        offer_rsp(32'h2001, 5'd2);
        cyc();
        offer_rsp(32'h2002, 5'd3);
        cyc();
        li.rev.v = 1'b0;
        rsp_yumi = 1'b1;
        cyc();
        rsp_yumi = 1'b0;
        #1;
        check("pre_rst_credits", 64'(credits), 64'd9);
        check("pre_rst_rsp_v", 64'(rsp_v), 64'd1);
        check("pre_rst_in_v", 64'(in_v), 64'd1);
        rst = 1'b1;
        q_rsp.delete();
        cyc();
        rst = 1'b0;
        #1;
        check("mid_rst_credits", 64'(credits), 64'd16);
        check("mid_rst_rsp_v", 64'(rsp_v), 64'd0);
        check("mid_rst_in_v", 64'(in_v), 64'd0);

        // Normal operation resumes.
        p = mk_pkt(op_load, 5'd6, 32'h0, 4'd0, 3'd0, 8'h77);
        host_req_v = 1'b1;
        host_req   = p;
        q_fwd.push_back(p);
        cyc();
        host_req_v = 1'b0;
        #1;
        check("post_rst_credits", 64'(credits), 64'd15);
        cyc();

        check("q_fwd_drained", 64'(q_fwd.size()), 64'd0);
        check("q_rsp_drained", 64'(q_rsp.size()), 64'd0);
        check("q_rev_drained", 64'(q_rev.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
